// File: rtl/urv_muldiv_seq.sv
// Sequential RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide sharing one iterative datapath, BITS_PER_CYCLE bits per clock.
module urv_muldiv_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            x_stall_req_o,
    input  logic            d_valid_i,
    input  logic            d_is_muldiv_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_done_o
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          fun_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q;   // product, or {remainder, dividend/quotient}
    logic [2*XLEN-1:0]   opa_q;   // shifted multiplicand
    logic [XLEN-1:0]     opb_q;   // multiplier (shifted) or divisor
    logic [XLEN-1:0]     rd_q;

    logic                start;
    logic                rs1_signed, rs2_signed, sa, sb, neg_in;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_res;

    assign start = d_valid_i & d_is_muldiv_i & ~x_kill_i;
    assign rs1_s = d_rs1_i;
    assign rs2_s = d_rs2_i;

    // Operand decode for the start cycle
    always_comb begin
        rs1_signed = (d_fun_i == 3'd1) | (d_fun_i == 3'd2) | (d_fun_i == 3'd4) | (d_fun_i == 3'd6);
        rs2_signed = (d_fun_i == 3'd1) | (d_fun_i == 3'd4) | (d_fun_i == 3'd6);
        sa         = rs1_signed & (rs1_s < 0);
        sb         = rs2_signed & (rs2_s < 0);
        a_mag      = sa ? -d_rs1_i : d_rs1_i;
        b_mag      = sb ? -d_rs2_i : d_rs2_i;
        // Remainder takes the dividend's sign; everything else the xor of both.
        neg_in     = (d_fun_i == 3'd6) ? sa : (sa ^ sb);
        div_zero   = (d_rs2_i == '0);
        div_ovf    = ((d_fun_i == 3'd4) | (d_fun_i == 3'd6)) &
                     (d_rs1_i == MIN_INT) & (d_rs2_i == '1);
        special    = d_fun_i[2] & (div_zero | div_ovf);
        if (d_fun_i[1])
            special_res = div_zero ? d_rs1_i : '0;
        else
            special_res = div_zero ? '1 : MIN_INT;
    end

    logic [2*XLEN-1:0] addend, acc_nxt, opa_nxt, prod_fix;
    logic [XLEN-1:0]   opb_nxt, rrem, dvd_w, q_fix, r_fix, res;
    logic [XLEN:0]     rem_w;

    // One iteration of the shared datapath plus final sign correction
    always_comb begin
        addend = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (opb_q[i])
                addend = addend + (opa_q << i);
        rrem  = acc_q[2*XLEN-1:XLEN];
        dvd_w = acc_q[XLEN-1:0];
        rem_w = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_w = {rrem, dvd_w[XLEN-1]};
            dvd_w = {dvd_w[XLEN-2:0], 1'b0};
            if (rem_w >= {1'b0, opb_q}) begin
                rem_w    = rem_w - {1'b0, opb_q};
                dvd_w[0] = 1'b1;
            end
            rrem = rem_w[XLEN-1:0];
        end
        if (fun_q[2]) begin
            acc_nxt = {rrem, dvd_w};
            opa_nxt = opa_q;
            opb_nxt = opb_q;
        end else begin
            acc_nxt = acc_q + addend;
            opa_nxt = opa_q << BITS_PER_CYCLE;
            opb_nxt = opb_q >> BITS_PER_CYCLE;
        end
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        q_fix    = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        r_fix    = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (fun_q)
            3'd0:          res = prod_fix[XLEN-1:0];
            3'd4, 3'd5:    res = q_fix;
            3'd6, 3'd7:    res = r_fix;
            default:       res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? DONE : BUSY;
            BUSY:    if (cnt_q == CNT_LAST) state_nxt = DONE;
            DONE:    if (!x_stall_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (x_kill_i)
            state_nxt = IDLE;
    end

    assign x_stall_req_o = ~x_kill_i & (((state == IDLE) & start) | (state == BUSY));
    assign x_done_o      = ~x_kill_i & (state == DONE);
    assign x_rd_o        = rd_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            fun_q <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nxt;
            if (x_kill_i) begin
                rd_q <= '0;
            end else if (state == IDLE && start) begin
                fun_q <= d_fun_i;
                neg_q <= neg_in;
                cnt_q <= '0;
                acc_q <= d_fun_i[2] ? {{XLEN{1'b0}}, a_mag} : '0;
                opa_q <= {{XLEN{1'b0}}, a_mag};
                opb_q <= b_mag;
                if (special)
                    rd_q <= special_res;
            end else if (state == BUSY) begin
                acc_q <= acc_nxt;
                opa_q <= opa_nxt;
                opb_q <= opb_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST)
                    rd_q <= res;
            end
        end
    end

endmodule

// File: tb/tb_urv_muldiv_seq.sv
// Directed bench for urv_muldiv_seq: a one-bit-per-cycle and a four-bit-per-cycle instance.
module tb_urv_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_stall = 1'b0;
    logic        x_kill = 1'b0;
    logic        valid1 = 1'b0, valid4 = 1'b0;
    logic        is_md = 1'b1;
    logic [2:0]  fun = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        stall1, stall4, done1, done4;
    logic [31:0] rd1, rd4;
    logic        sel = 1'b0;
    logic        cur_stall, cur_done;
    logic [31:0] cur_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    urv_muldiv_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall1), .d_valid_i(valid1), .d_is_muldiv_i(is_md),
        .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd1), .x_done_o(done1));

    urv_muldiv_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall4), .d_valid_i(valid4), .d_is_muldiv_i(is_md),
        .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd4), .x_done_o(done4));

    assign cur_stall = sel ? stall4 : stall1;
    assign cur_done  = sel ? done4 : done1;
    assign cur_rd    = sel ? rd4 : rd1;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t vecs [0:15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one op at a negedge and count stall-request cycles until it drops.
    task automatic run_op(input logic s, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int st, output logic dn);
        sel = s;
        @(negedge clk);
        fun = f; rs1 = a; rs2 = b;
        if (s) valid4 = 1'b1; else valid1 = 1'b1;
        st = 0;
        #1;
        while (cur_stall === 1'b1 && st < 200) begin
            st++;
            @(negedge clk);
            valid1 = 1'b0; valid4 = 1'b0;
            #1;
        end
        res = cur_rd;
        dn  = cur_done;
    endtask

    initial begin
        logic [31:0] res;
        int          st;
        logic        dn;
        logic        seen;

        vecs[0]  = '{3'd5, 32'd100,       32'd7,        32'd14,       33};
        vecs[1]  = '{3'd7, 32'd100,       32'd7,        32'd2,        33};
        vecs[2]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
        vecs[3]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
        vecs[4]  = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        vecs[5]  = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
        vecs[6]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF, 1};
        vecs[7]  = '{3'd7, 32'd5,         32'd0,        32'd5,        1};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1};
        vecs[10] = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000, 33};
        vecs[11] = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[12] = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vecs[13] = '{3'd0, 32'hFFFFFFFD,  32'd5,        32'hFFFFFFF1, 33};
        vecs[14] = '{3'd1, 32'hFFFFFFFD,  32'd5,        32'hFFFFFFFF, 33};
        vecs[15] = '{3'd0, 32'h12345678,  32'h10,       32'h23456780, 33};

        repeat (3) @(negedge clk);
        check("reset_stall", {31'd0, stall1 | stall4}, 32'd0);
        check("reset_done",  {31'd0, done1 | done4},   32'd0);
        check("reset_rd1",   rd1, 32'd0);
        check("reset_rd4",   rd4, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(1'b0, vecs[i].fun, vecs[i].a, vecs[i].b, res, st, dn);
            check($sformatf("vec%0d_stalls", i), st, vecs[i].stalls);
            check($sformatf("vec%0d_done", i), {31'd0, dn}, 32'd1);
            check($sformatf("vec%0d_rd", i), res, vecs[i].exp);
            @(negedge clk); #1;
            check($sformatf("vec%0d_done_drop", i), {31'd0, cur_done}, 32'd0);
        end

        // Reset pulse in BUSY cycle 5, with the previous result still on x_rd_o
        sel = 1'b0;
        @(negedge clk);
        fun = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; valid1 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            valid1 = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_stall", {31'd0, stall1}, 32'd0);
        check("rst_mid_done",  {31'd0, done1},  32'd0);
        check("rst_mid_rd",    rd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            seen = seen | stall1 | done1;
        end
        check("rst_no_residual", {31'd0, seen}, 32'd0);

        // Kill in BUSY cycle 10
        @(negedge clk);
        fun = 3'd5; rs1 = 32'd100; rs2 = 32'd7; valid1 = 1'b1;
        #1;
        check("kill_start_stall", {31'd0, stall1}, 32'd1);
        repeat (11) begin
            @(negedge clk);
            valid1 = 1'b0;
        end
        x_kill = 1'b1;
        #1;
        check("kill_stall_same_cycle", {31'd0, stall1}, 32'd0);
        @(negedge clk);
        x_kill = 1'b0;
        #1;
        check("kill_idle_stall", {31'd0, stall1}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            seen = seen | done1 | stall1;
        end
        check("kill_never_done", {31'd0, seen}, 32'd0);

        // Back-to-back after a killed op still works
        run_op(1'b0, 3'd5, 32'd100, 32'd7, res, st, dn);
        check("after_kill_rd", res, 32'd14);
        check("after_kill_stalls", st, 33);
        @(negedge clk);

        // Four bits per cycle, then hold DONE under an external stall
        run_op(1'b1, 3'd5, 32'hFFFFFFFF, 32'd3, res, st, dn);
        x_stall = 1'b1;
        valid4 = 1'b1;
        check("b4_stalls", st, 9);
        check("b4_done", {31'd0, dn}, 32'd1);
        check("b4_rd", res, 32'h55555555);
        repeat (3) begin
            @(negedge clk); #1;
            check("b4_hold_done", {31'd0, done4}, 32'd1);
            check("b4_hold_rd", rd4, 32'h55555555);
            check("b4_hold_stall", {31'd0, stall4}, 32'd0);
        end
        valid4 = 1'b0;
        x_stall = 1'b0;
        @(negedge clk); #1;
        check("b4_release_done", {31'd0, done4}, 32'd0);
        check("b4_release_stall", {31'd0, stall4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/urv_muldiv_seq.md
Name: urv_muldiv_seq

Overview:
Sequential RV32M/RV64M multiply/divide unit for the execute stage. It covers all eight M-extension functions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a shared iterative datapath that retires BITS_PER_CYCLE bits per clock. While an operation runs it holds the pipeline through x_stall_req_o, which feeds the exec-stage stall request. Its result is taken through the RD_SOURCE_DIVIDE mux leg.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
BITS_PER_CYCLE, 1, bits retired per iteration; one of 1, 2, 4; must divide XLEN.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
x_stall_i  in  1  global execute-stage stall (may include this block's own request)
x_kill_i  in  1  flush of the instruction in execute
x_stall_req_o  out  1  stall request while an operation is pending
d_valid_i  in  1  valid instruction in execute
d_is_muldiv_i  in  1  instruction is M-extension
d_fun_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
d_rs1_i  in  XLEN  operand A
d_rs2_i  in  XLEN  operand B
x_rd_o  out  XLEN  result; valid when x_done_o=1
x_done_o  out  1  result valid for the current instruction

Behaviour:
- N = XLEN/BITS_PER_CYCLE iterations. The counter is clog2(N+1) bits wide.
- States are IDLE, BUSY and DONE. Reset (async) puts the block in IDLE with x_rd_o=0, x_done_o=0 and all internal registers cleared.
- start = d_valid_i & d_is_muldiv_i & !x_kill_i, evaluated in IDLE. x_stall_req_o is combinational: (IDLE & start) | BUSY.
- IDLE & start:
  - latch fun and operand magnitudes, plus result-sign flags per signedness (MULH: both signed; MULHSU: rs1 signed only; DIV/REM: both signed).
  - clear the counter and go to BUSY.
  - fast path (div/rem only): on divide-by-zero or signed overflow, skip BUSY and go straight to DONE with the special result.
- BUSY, multiply: shift-add on a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
- BUSY, divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
- BUSY exit: when the counter reaches N-1, apply sign correction (two's-complement negate of the 2*XLEN product, quotient or remainder as required), register x_rd_o and go to DONE.
- Result select:
  - MUL gives product[XLEN-1:0]; MULH/MULHSU/MULHU give product[2XLEN-1:XLEN].
  - DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Remainder sign follows the dividend.
- Special cases:
  - divisor 0: quotient = all ones, remainder = rs1.
  - DIV/REM with rs1=MIN_INT and rs2=-1: quotient = MIN_INT, remainder = 0.
- DONE:
  - x_done_o=1 and x_stall_req_o=0; x_rd_o is held.
  - if !x_stall_i, the instruction advances: go to IDLE and drop x_done_o on the next edge.
  - if x_stall_i=1 (another stall source), stay in DONE holding the result.
  - no restart while in DONE, so the same instruction is never executed twice.
- Latency from the start cycle to result: N+1 cycles of asserted stall for the normal path, 1 cycle for the fast path.
- Example: XLEN=32, B=1 gives 33 stall cycles; B=4 gives 9.
- x_kill_i in any state forces IDLE on the next edge: x_done_o=0, x_stall_req_o=0 combinationally from that cycle, and no result.
- d_valid_i dropping during BUSY has no effect; the operands are already latched.
- Back-to-back M instructions: the second starts from IDLE in the cycle after DONE is consumed.
- Reset asserted mid-operation: immediate IDLE and cleared outputs. No residual stall after deassertion.

Test Plan:
- DIVU 100/7, XLEN=32, B=1 -> x_stall_req_o high for exactly 33 cycles, then x_done_o=1, x_rd_o=14. REMU with the same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 stall cycle. REM with the same operands -> 0.
- DIVU 5/0 -> 0xFFFFFFFF after 1 stall cycle. REMU 5/0 -> 5.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x12345678*0x10 -> 0x23456780.
- x_kill_i at BUSY cycle 10 -> x_stall_req_o=0 that cycle, IDLE next cycle, x_done_o never set. Reset pulse at BUSY cycle 5 -> outputs 0 immediately.
- B=4 DIVU 0xFFFFFFFF/3 -> 9 stall cycles, x_rd_o=0x55555555. In DONE, hold x_stall_i=1 for 3 cycles -> x_rd_o stable with x_done_o=1 throughout, and no new start.
